// File: rtl/multi_set_if.sv
// Handshake and result bundle for multi_set.
// Define SET_POINT_STREAM_EN to add the per-point stream signals (pt_valid, pt_x, pt_y).
interface multi_set_if #(
  parameter int NCIRC = 4,
  parameter int CW    = 4
);
  logic                    en;
  logic [NCIRC*2*CW-1:0]   central;
  logic [NCIRC*CW-1:0]     radius;
  logic [2:0]              mode;
  logic                    busy;
  logic                    valid;
  logic [2*CW:0]           candidate;
`ifdef SET_POINT_STREAM_EN
  logic                    pt_valid;
  logic [CW-1:0]           pt_x;
  logic [CW-1:0]           pt_y;

  modport master (
    output en, central, radius, mode,
    input  busy, valid, candidate, pt_valid, pt_x, pt_y
  );
  modport slave (
    input  en, central, radius, mode,
    output busy, valid, candidate, pt_valid, pt_x, pt_y
  );
`else
  modport master (
    output en, central, radius, mode,
    input  busy, valid, candidate
  );
  modport slave (
    input  en, central, radius, mode,
    output busy, valid, candidate
  );
`endif
endinterface

// File: rtl/multi_set.sv
// Counts grid points 1..GRID x 1..GRID that satisfy a set operation over NCIRC circles.
// Optional macro SET_POINT_STREAM_EN adds a stream of the counted points (pt_valid/pt_x/pt_y).
module multi_set #(
  parameter int NCIRC = 4,
  parameter int CW    = 4,
  parameter int GRID  = 8
) (
  input  logic        clk,
  input  logic        rst,
  multi_set_if.slave  bus
);

  localparam int PW = 2*CW+1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q,   state_d;
  logic [NCIRC*2*CW-1:0] central_q, central_d;
  logic [NCIRC*CW-1:0]   radius_q,  radius_d;
  logic [2:0]            mode_q,    mode_d;
  logic [CW-1:0]         px_q,      px_d;
  logic [CW-1:0]         py_q,      py_d;
  logic                  drain_q,   drain_d;
  logic                  vld_p1_q,  vld_p1_d;
  logic [NCIRC-1:0]      memb_p1_q, memb_p1_d;
  logic [PW-1:0]         cand_q,    cand_d;
  logic [NCIRC-1:0]      memb_p0;
  logic                  hit_p2;
`ifdef SET_POINT_STREAM_EN
  logic [CW-1:0]         ptx_p1_q,  ptx_p1_d;
  logic [CW-1:0]         pty_p1_q,  pty_p1_d;
  logic                  pt_vld_q,  pt_vld_d;
  logic [CW-1:0]         pt_x_q,    pt_x_d;
  logic [CW-1:0]         pt_y_q,    pt_y_d;
`endif

  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic signed [CW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? CW'(-d) : CW'(d);
  endfunction

  function automatic logic [2*CW-1:0] square(input logic [CW-1:0] v);
    logic [2*CW-1:0] w;
    w = {{CW{1'b0}}, v};
    return w * w;
  endfunction

  function automatic logic [PW-1:0] dist_sq(input logic [CW-1:0] dx, input logic [CW-1:0] dy);
    return {1'b0, square(dx)} + {1'b0, square(dy)};
  endfunction

  function automatic logic [3:0] popcount(input logic [NCIRC-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NCIRC; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  function automatic logic mode_hit(input logic [2:0] m, input logic [NCIRC-1:0] v);
    logic h;
    case (m)
      3'd0:    h = v[0];
      3'd1:    h = &v;
      3'd2:    h = |v;
      3'd3:    h = ^v;
      3'd4:    h = (popcount(v) == 4'd1);
      3'd5:    h = (popcount(v) == 4'd2);
      default: h = 1'b0;
    endcase
    return h;
  endfunction

  // Stage 0: membership of the presented point in every circle; squares are full width
  always_comb begin : memb_calc
    logic [CW-1:0] cx, cy, r;
    memb_p0 = '0;
    for (int i = 0; i < NCIRC; i++) begin
      cx = central_q[i*2*CW+CW +: CW];
      cy = central_q[i*2*CW    +: CW];
      r  = radius_q[i*CW +: CW];
      memb_p0[i] = dist_sq(abs_diff(px_q, cx), abs_diff(py_q, cy)) <= {1'b0, square(r)};
    end
  end

  // Stage 2 decision on the registered membership vector
  assign hit_p2 = vld_p1_q && mode_hit(mode_q, memb_p1_q);

  always_comb begin
    state_d   = state_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    px_d      = px_q;
    py_d      = py_q;
    drain_d   = drain_q;
    vld_p1_d  = (state_q == S_SCAN);
    memb_p1_d = memb_p0;
    cand_d    = hit_p2 ? cand_q + PW'(1) : cand_q;
`ifdef SET_POINT_STREAM_EN
    ptx_p1_d  = px_q;
    pty_p1_d  = py_q;
    pt_vld_d  = hit_p2;
    pt_x_d    = hit_p2 ? ptx_p1_q : pt_x_q;
    pt_y_d    = hit_p2 ? pty_p1_q : pt_y_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          central_d = bus.central;
          radius_d  = bus.radius;
          mode_d    = bus.mode;
          cand_d    = '0;
          px_d      = CW'(1);
          py_d      = CW'(1);
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (px_q == CW'(GRID)) begin
          px_d = CW'(1);
          if (py_q == CW'(GRID)) begin
            drain_d = 1'b0;
            state_d = S_DRAIN;
          end else begin
            py_d = py_q + CW'(1);
          end
        end else begin
          px_d = px_q + CW'(1);
        end
      end
      // Two cycles let the last point pass both pipeline stages
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      px_q      <= '0;
      py_q      <= '0;
      drain_q   <= 1'b0;
      vld_p1_q  <= 1'b0;
      memb_p1_q <= '0;
      cand_q    <= '0;
    end else begin
      state_q   <= state_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      px_q      <= px_d;
      py_q      <= py_d;
      drain_q   <= drain_d;
      vld_p1_q  <= vld_p1_d;
      memb_p1_q <= memb_p1_d;
      cand_q    <= cand_d;
    end
  end

`ifdef SET_POINT_STREAM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptx_p1_q <= '0;
      pty_p1_q <= '0;
      pt_vld_q <= 1'b0;
      pt_x_q   <= '0;
      pt_y_q   <= '0;
    end else begin
      ptx_p1_q <= ptx_p1_d;
      pty_p1_q <= pty_p1_d;
      pt_vld_q <= pt_vld_d;
      pt_x_q   <= pt_x_d;
      pt_y_q   <= pt_y_d;
    end
  end

  assign bus.pt_valid = pt_vld_q;
  assign bus.pt_x     = pt_x_q;
  assign bus.pt_y     = pt_y_q;
`endif

  assign bus.busy      = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign bus.valid     = (state_q == S_DONE);
  assign bus.candidate = cand_q;

endmodule

// File: tb/tb_multi_set.sv
// Table-driven bench for multi_set with a result scoreboard and corner-case sequences.
module tb_multi_set;
  localparam int NCIRC = 4;
  localparam int CW    = 4;
  localparam int GRID  = 8;
  localparam int LAT   = GRID*GRID + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_set_if #(.NCIRC(NCIRC), .CW(CW)) bus();
  multi_set #(.NCIRC(NCIRC), .CW(CW), .GRID(GRID)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    logic [31:0] central;
    logic [15:0] radius;
    logic [2:0]  mode;
    int          exp;
  } vec_t;

  vec_t vecs[12];
  int   sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [31:0] pc(input int x0, input int y0, input int x1, input int y1,
                                      input int x2, input int y2, input int x3, input int y3);
    return {4'(x3), 4'(y3), 4'(x2), 4'(y2), 4'(x1), 4'(y1), 4'(x0), 4'(y0)};
  endfunction

  function automatic logic [15:0] pr(input int r0, input int r1, input int r2, input int r3);
    return {4'(r3), 4'(r2), 4'(r1), 4'(r0)};
  endfunction

`ifdef SET_POINT_STREAM_EN
  logic [7:0] pt_log[$];
  always @(negedge clk) if (bus.pt_valid) pt_log.push_back({bus.pt_x, bus.pt_y});
`endif

  task automatic start_job(input vec_t v);
    @(negedge clk);
    bus.central = v.central;
    bus.radius  = v.radius;
    bus.mode    = v.mode;
    bus.en      = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input bit perturb, input bit en_in_done);
    int  cyc;
    int  exp;
    int  fin;
    bit  seen;
    seen = 1'b0;
    cyc  = 0;
    sb.push_back(v.exp);
    start_job(v);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (perturb && c == 10) begin
        bus.central = pc(1, 1, 8, 8, 1, 8, 8, 1);
        bus.radius  = pr(0, 0, 0, 0);
        bus.mode    = 3'd2;
        bus.en      = 1'b1;
      end
      if (perturb && c == 12) bus.en = 1'b0;
      if (bus.valid) begin
        seen = 1'b1;
        cyc  = c;
        break;
      end
    end
    exp = sb.pop_front();
    if (!seen) begin
      chk({v.name, " timeout"}, 0, 1);
      return;
    end
    chk({v.name, " latency"}, cyc, LAT);
    chk({v.name, " busy@valid"}, int'(bus.busy), 0);
    chk({v.name, " candidate"}, int'(bus.candidate), exp);
    fin = int'(bus.candidate);
    if (en_in_done) begin
      bus.central = pc(4, 4, 4, 4, 4, 4, 4, 4);
      bus.radius  = pr(15, 15, 15, 15);
      bus.mode    = 3'd1;
      bus.en      = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    chk({v.name, " valid drop"}, int'(bus.valid), 0);
    chk({v.name, " idle busy"}, int'(bus.busy), 0);
    chk({v.name, " cand hold"}, int'(bus.candidate), fin);
    if (en_in_done) begin
      @(posedge clk);
      #1;
      chk({v.name, " no accept in done"}, int'(bus.busy), 0);
    end
  endtask

  initial begin
    int vcount;
    vecs[0]  = '{"m0_disk_r2",   pc(4,4,4,4,4,4,4,4), pr(2,2,2,2),    3'd0, 13};
    vecs[1]  = '{"m1_and",       pc(4,4,4,4,4,4,4,4), pr(2,1,15,15),  3'd1, 5};
    vecs[2]  = '{"m2_corners",   pc(1,1,8,8,1,8,8,1), pr(0,0,0,0),    3'd2, 4};
    vecs[3]  = '{"m4_one",       pc(1,1,8,8,0,0,0,0), pr(15,0,0,0),   3'd4, 63};
    vecs[4]  = '{"m3_xor",       pc(1,1,8,8,0,0,0,0), pr(15,0,0,0),   3'd3, 63};
    vecs[5]  = '{"m5_two",       pc(1,1,8,8,0,0,0,0), pr(15,0,0,0),   3'd5, 1};
    vecs[6]  = '{"m6_rsvd",      pc(1,1,8,8,0,0,0,0), pr(15,0,0,0),   3'd6, 0};
    vecs[7]  = '{"m7_rsvd",      pc(1,1,8,8,0,0,0,0), pr(15,0,0,0),   3'd7, 0};
    vecs[8]  = '{"m5_nested",    pc(4,4,4,4,4,4,4,4), pr(2,1,15,15),  3'd5, 51};
    vecs[9]  = '{"m3_nested",    pc(4,4,4,4,4,4,4,4), pr(2,1,15,15),  3'd3, 8};
    vecs[10] = '{"m0_off_grid",  pc(0,4,0,0,0,0,0,0), pr(2,0,0,0),    3'd0, 4};
    vecs[11] = '{"m4_nested",    pc(4,4,4,4,4,4,4,4), pr(2,1,15,15),  3'd4, 0};
    vcount = 12;

    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.central = '0;
    bus.radius  = '0;
    bus.mode    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset valid", int'(bus.valid), 0);
    chk("reset candidate", int'(bus.candidate), 0);
`ifdef SET_POINT_STREAM_EN
    chk("reset pt_valid", int'(bus.pt_valid), 0);
    chk("reset pt_xy", int'({bus.pt_x, bus.pt_y}), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vcount; i++) run_job(vecs[i], 1'b0, 1'b0);

    // Abort mid-scan, then rerun
    start_job(vecs[0]);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", int'(bus.busy), 0);
    chk("abort valid", int'(bus.valid), 0);
    chk("abort candidate", int'(bus.candidate), 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int vhi;
      vhi = 0;
      for (int c = 0; c < 80; c++) begin
        @(posedge clk);
        #1;
        if (bus.valid || bus.busy) vhi++;
      end
      chk("abort no activity", vhi, 0);
    end
    run_job(vecs[0], 1'b0, 1'b0);

    // Inputs changed and en pulsed during the scan must not restart
    run_job(vecs[0], 1'b1, 1'b0);

    // en in the DONE cycle is ignored
    run_job(vecs[1], 1'b0, 1'b1);

`ifdef SET_POINT_STREAM_EN
    pt_log.delete();
    run_job(vecs[2], 1'b0, 1'b0);
    chk("stream count", pt_log.size(), 4);
    if (pt_log.size() == 4) begin
      chk("stream pt0", int'(pt_log[0]), int'(8'h11));
      chk("stream pt1", int'(pt_log[1]), int'(8'h81));
      chk("stream pt2", int'(pt_log[2]), int'(8'h18));
      chk("stream pt3", int'(pt_log[3]), int'(8'h88));
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
